// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg: shared UART constants, status-flag indices, helpers     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int UART_NFLAGS = 8;

  localparam int FLG_RXRDY   = 0;
  localparam int FLG_TXEMPTY = 1;
  localparam int FLG_FRAME   = 2;
  localparam int FLG_PARITY  = 3;
  localparam int FLG_RXOVR   = 4;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_flag_cell.sv
// +------------------------------------------------------------------+
// | rs_flag_cell: one sticky set/reset flag with edge detect + ovf    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module rs_flag_cell
  import uart_pkg::*;
#(
  parameter bit SET_DOMINANT = 1'b0,
  parameter bit EDGE_SET     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic w1c,
  output logic flag,
  output logic ovf
);

  logic set_q;
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;
  logic set_ev, clr_ev;

  always_comb begin
    set_ev = EDGE_SET ? (set & ~set_q) : set;
    clr_ev = clr | w1c;

    flag_d = flag_q;
    if (set_ev && clr_ev) begin
      flag_d = SET_DOMINANT;
    end else if (set_ev) begin
      flag_d = 1'b1;
    end else if (clr_ev) begin
      flag_d = 1'b0;
    end

    // Hardware clr does not clear ovf; only the bus W1C does, and it beats a fresh overflow.
    ovf_d = ovf_q;
    if (w1c) begin
      ovf_d = 1'b0;
    end else if (set_ev && flag_q && !clr_ev) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q  <= 1'b0;
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      set_q  <= set;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign flag = flag_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: rtl/rs_flag_bank.sv
// +------------------------------------------------------------------+
// | rs_flag_bank: NCH sticky status flags, mask, irq and pending ID   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module rs_flag_bank
  import uart_pkg::*;
#(
  parameter int NCH          = UART_NFLAGS,
  parameter bit SET_DOMINANT = 1'b0,
  parameter bit EDGE_SET     = 1'b1,
  parameter int IDW          = id_width(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] set,
  input  logic [NCH-1:0] clr,
  input  logic           wr_clr,
  input  logic [NCH-1:0] wr_data,
  input  logic           ld_mask,
  input  logic [NCH-1:0] mask_in,
  output logic [NCH-1:0] flags,
  output logic [NCH-1:0] ovf,
  output logic [NCH-1:0] mask,
  output logic           irq,
  output logic [IDW-1:0] pending_id
);

  logic [NCH-1:0] mask_q, mask_d;
  logic           irq_q, irq_d;
  logic [IDW-1:0] pending_id_q, pending_id_d;
  logic [NCH-1:0] w1c;
  logic [NCH-1:0] pending;

  assign w1c = {NCH{wr_clr}} & wr_data;

  for (genvar g = 0; g < NCH; g++) begin : g_cell
    rs_flag_cell #(
      .SET_DOMINANT(SET_DOMINANT),
      .EDGE_SET    (EDGE_SET)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .set (set[g]),
      .clr (clr[g]),
      .w1c (w1c[g]),
      .flag(flags[g]),
      .ovf (ovf[g])
    );
  end

  assign pending = flags & mask_q;

  always_comb begin
    mask_d = ld_mask ? mask_in : mask_q;
    irq_d  = |pending;
    // Scan high to low so the lowest pending index is the one left standing.
    pending_id_d = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pending_id_d = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q       <= '0;
      irq_q        <= 1'b0;
      pending_id_q <= '0;
    end else begin
      mask_q       <= mask_d;
      irq_q        <= irq_d;
      pending_id_q <= pending_id_d;
    end
  end

  assign mask       = mask_q;
  assign irq        = irq_q;
  assign pending_id = pending_id_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_flag_bank.sv
// Bench: three rs_flag_bank variants (clear-dominant edge, set-dominant edge, clear-dominant level)
// share one directed stimulus and are checked every cycle against a behavioural model.
`default_nettype none

module tb_rs_flag_bank;

  localparam int NK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] set = '0;
  logic [7:0] clr = '0;
  logic       wr_clr = 1'b0;
  logic [7:0] wr_data = '0;
  logic       ld_mask = 1'b0;
  logic [7:0] mask_in = '0;

  logic [NK-1:0][7:0] d_flags, d_ovf, d_mask;
  logic [NK-1:0]      d_irq;
  logic [NK-1:0][2:0] d_pid;

  int checks = 0;
  int errors = 0;

  bit sd_cfg [NK] = '{1'b0, 1'b1, 1'b0};
  bit es_cfg [NK] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  rs_flag_bank #(.NCH(8), .SET_DOMINANT(1'b0), .EDGE_SET(1'b1), .IDW(3)) u_dut0 (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .wr_clr(wr_clr), .wr_data(wr_data),
    .ld_mask(ld_mask), .mask_in(mask_in), .flags(d_flags[0]), .ovf(d_ovf[0]),
    .mask(d_mask[0]), .irq(d_irq[0]), .pending_id(d_pid[0]));

  rs_flag_bank #(.NCH(8), .SET_DOMINANT(1'b1), .EDGE_SET(1'b1), .IDW(3)) u_dut1 (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .wr_clr(wr_clr), .wr_data(wr_data),
    .ld_mask(ld_mask), .mask_in(mask_in), .flags(d_flags[1]), .ovf(d_ovf[1]),
    .mask(d_mask[1]), .irq(d_irq[1]), .pending_id(d_pid[1]));

  rs_flag_bank #(.NCH(8), .SET_DOMINANT(1'b0), .EDGE_SET(1'b0), .IDW(3)) u_dut2 (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .wr_clr(wr_clr), .wr_data(wr_data),
    .ld_mask(ld_mask), .mask_in(mask_in), .flags(d_flags[2]), .ovf(d_ovf[2]),
    .mask(d_mask[2]), .irq(d_irq[2]), .pending_id(d_pid[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-variant flag/ovf bits plus a shared set history and mask.
  logic [7:0] m_flags [NK];
  logic [7:0] m_ovf   [NK];
  logic       m_irq   [NK];
  logic [2:0] m_pid   [NK];
  logic [7:0] m_mask;
  logic [7:0] m_prev_set;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) begin
        m_flags[k] = '0; m_ovf[k] = '0; m_irq[k] = 1'b0; m_pid[k] = '0;
      end
      m_mask     = '0;
      m_prev_set = '0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        logic [7:0] nf, no, pend;
        bit found;
        pend = m_flags[k] & m_mask;
        m_irq[k] = (pend != 0);
        m_pid[k] = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (!found && pend[i]) begin
            m_pid[k] = 3'(i);
            found = 1'b1;
          end
        end
        for (int i = 0; i < 8; i++) begin
          bit rise, wipe, kill, had;
          rise = es_cfg[k] ? (set[i] && !m_prev_set[i]) : set[i];
          wipe = wr_clr && wr_data[i];
          kill = clr[i] || wipe;
          had  = m_flags[k][i];
          if (rise && kill)  nf[i] = sd_cfg[k];
          else if (rise)     nf[i] = 1'b1;
          else if (kill)     nf[i] = 1'b0;
          else               nf[i] = had;
          if (wipe)                      no[i] = 1'b0;
          else if (rise && had && !kill) no[i] = 1'b1;
          else                           no[i] = m_ovf[k][i];
        end
        m_flags[k] = nf;
        m_ovf[k]   = no;
      end
      m_prev_set = set;
      if (ld_mask) m_mask = mask_in;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("dut%0d flags", k), 32'(d_flags[k]), 32'(m_flags[k]));
      chk($sformatf("dut%0d ovf", k),   32'(d_ovf[k]),   32'(m_ovf[k]));
      chk($sformatf("dut%0d mask", k),  32'(d_mask[k]),  32'(m_mask));
      chk($sformatf("dut%0d irq", k),   32'(d_irq[k]),   32'(m_irq[k]));
      chk($sformatf("dut%0d pid", k),   32'(d_pid[k]),   32'(m_pid[k]));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_all();
    set = '0; clr = '0; wr_clr = 1'b1; wr_data = 8'hFF;
    step();
    wr_clr = 1'b0; wr_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    chk("reset flags", 32'(d_flags[0]), 32'h00);
    chk("reset irq", 32'(d_irq[0]), 32'h0);

    // T1: set is high in the first cycle after reset release -> counts as an edge
    rst = 1'b0;
    set = 8'h04;
    step();
    chk("t1 flags", 32'(d_flags[0]), 32'h04);
    set = 8'h00; ld_mask = 1'b1; mask_in = 8'h04;
    step();
    chk("t1 irq before mask seen", 32'(d_irq[0]), 32'h0);
    ld_mask = 1'b0;
    step();
    chk("t1 irq", 32'(d_irq[0]), 32'h1);
    chk("t1 pid", 32'(d_pid[0]), 32'h2);
    clear_all();

    // T2: simultaneous set+clr on ch5
    set = 8'h20; clr = 8'h20;
    step();
    chk("t2 clr-dominant", 32'(d_flags[0][5]), 32'h0);
    chk("t2 set-dominant", 32'(d_flags[1][5]), 32'h1);
    set = '0; clr = '0;
    step();
    clear_all();

    // T3: overflow on ch1, hardware clear keeps ovf, W1C clears it
    set = 8'h02; step();
    set = 8'h00; step();
    set = 8'h02; step();
    chk("t3 ovf set", 32'(d_ovf[0]), 32'h02);
    set = 8'h00; clr = 8'h02; step();
    chk("t3 flag cleared", 32'(d_flags[0][1]), 32'h0);
    chk("t3 ovf sticky", 32'(d_ovf[0]), 32'h02);
    clr = 8'h00; wr_clr = 1'b1; wr_data = 8'h02; step();
    chk("t3 ovf w1c", 32'(d_ovf[0]), 32'h00);
    wr_clr = 1'b0; wr_data = '0;
    clear_all();

    // T4: set[0] held high, W1C at cycle 4
    for (int c = 0; c < 10; c++) begin
      set = 8'h01;
      wr_clr = (c == 4);
      wr_data = 8'h01;
      step();
      if (c >= 4) chk("t4 edge stays clear", 32'(d_flags[0][0]), 32'h0);
      else        chk("t4 edge set", 32'(d_flags[0][0]), 32'h1);
      if (c == 4) chk("t4 level cleared", 32'(d_flags[2][0]), 32'h0);
      if (c == 5) chk("t4 level re-set", 32'(d_flags[2][0]), 32'h1);
    end
    wr_clr = 1'b0; wr_data = '0;
    clear_all();

    // T5: priority encoding and mask gating
    set = 8'h28; step();
    set = 8'h00; ld_mask = 1'b1; mask_in = 8'hFF; step();
    ld_mask = 1'b0; step();
    chk("t5 irq", 32'(d_irq[0]), 32'h1);
    chk("t5 pid3", 32'(d_pid[0]), 32'h3);
    wr_clr = 1'b1; wr_data = 8'h08; step();
    chk("t5 pid still 3", 32'(d_pid[0]), 32'h3);
    wr_clr = 1'b0; wr_data = '0; step();
    chk("t5 pid5", 32'(d_pid[0]), 32'h5);
    ld_mask = 1'b1; mask_in = 8'h00; step();
    ld_mask = 1'b0; step();
    chk("t5 masked irq", 32'(d_irq[0]), 32'h0);
    chk("t5 masked pid", 32'(d_pid[0]), 32'h0);

    // T6: asynchronous reset mid-operation
    set = 8'hFF; step();
    set = 8'h00; ld_mask = 1'b1; mask_in = 8'hFF; step();
    ld_mask = 1'b0; step();
    chk("t6 flags full", 32'(d_flags[0]), 32'hFF);
    chk("t6 irq up", 32'(d_irq[0]), 32'h1);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("t6 dut%0d flags", k), 32'(d_flags[k]), 32'h00);
      chk($sformatf("t6 dut%0d ovf", k),   32'(d_ovf[k]),   32'h00);
      chk($sformatf("t6 dut%0d mask", k),  32'(d_mask[k]),  32'h00);
      chk($sformatf("t6 dut%0d irq", k),   32'(d_irq[k]),   32'h0);
      chk($sformatf("t6 dut%0d pid", k),   32'(d_pid[k]),   32'h0);
    end
    step();
    rst = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
